// File: rtl/ex_div_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
package ex_div_ctrl_pkg;

  // Default operand width of the divide datapath.
  localparam int DIV_DATA_LEN = 32;

  // Sequencer states; encodings match the rest of the core's divide control.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer in front of the multi-cycle divider: latches operands,
// stalls the pipeline while the divider runs, handles flush, short-circuits
// divide-by-zero and registers {remainder, quotient} for the HI/LO write.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int                  DATA_LEN  = DIV_DATA_LEN,
  parameter logic [DATA_LEN-1:0] ZERO_QUOT = {DATA_LEN{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  signed_i,
  input  logic [DATA_LEN-1:0]   opdata1_i,
  input  logic [DATA_LEN-1:0]   opdata2_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  div_valid_o,
  output logic                  div_signed_o,
  output logic [DATA_LEN-1:0]   div_op1_o,
  output logic [DATA_LEN-1:0]   div_op2_o,
  input  logic                  div_ready_i,
  input  logic [2*DATA_LEN-1:0] div_result_i,
  output logic                  result_valid_o,
  output logic [2*DATA_LEN-1:0] result_o
);

  div_state_e            state;
  div_state_e            next_state;
  logic [DATA_LEN-1:0]   op1_q;
  logic [DATA_LEN-1:0]   op2_q;
  logic                  signed_q;
  logic [2*DATA_LEN-1:0] result_q;
  logic                  start;
  logic                  div_by_zero;
  logic                  stall_c;
  logic                  result_load;

  assign div_by_zero = (opdata2_i == '0);

  // State register; reset drops div_valid_o immediately by forcing IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    next_state     = state;
    start          = 1'b0;
    stall_c        = 1'b0;
    div_valid_o    = 1'b0;
    result_valid_o = 1'b0;
    result_load    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (req_i && !flush_i) begin
          start      = 1'b1;
          stall_c    = 1'b1;
          next_state = div_by_zero ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        div_valid_o = 1'b1;
        if (flush_i) begin
          next_state = DIV_IDLE;
        end else begin
          stall_c = 1'b1;
          if (div_ready_i) begin
            result_load = 1'b1;
            next_state  = DIV_DONE;
          end
        end
      end
      DIV_DONE: begin
        result_valid_o = !flush_i;
        next_state     = DIV_IDLE;
      end
      default: begin
        next_state = DIV_IDLE;
      end
    endcase
  end

  // Keep stall low while held in reset, even if EX still presents a request.
  assign stall_o = rst && stall_c;

  // Operand latches; captured only when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
    end else if (start) begin
      op1_q    <= opdata1_i;
      op2_q    <= opdata2_i;
      signed_q <= signed_i;
    end
  end

  // Result register; divide-by-zero bypasses the divider, otherwise capture its output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
    end else if (start && div_by_zero) begin
      result_q <= {opdata1_i, ZERO_QUOT};
    end else if (result_load) begin
      result_q <= div_result_i;
    end
  end

  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign div_signed_o = signed_q;
  assign result_o     = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed plus randomized bench for ex_div_ctrl with a cycle-counting
// divider stand-in and an arithmetic reference for the expected results.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        sgn_in;
  logic [31:0] op1_in;
  logic [31:0] op2_in;
  logic        flush;
  logic        stall;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_ready;
  logic [63:0] div_result;
  logic        result_valid;
  logic [63:0] result;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          div_cnt;
  logic [63:0] last_res;

  ex_div_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .signed_i       (sgn_in),
    .opdata1_i      (op1_in),
    .opdata2_i      (op2_in),
    .flush_i        (flush),
    .stall_o        (stall),
    .div_valid_o    (div_valid),
    .div_signed_o   (div_signed),
    .div_op1_o      (div_op1),
    .div_op2_o      (div_op2),
    .div_ready_i    (div_ready),
    .div_result_i   (div_result),
    .result_valid_o (result_valid),
    .result_o       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: {remainder, quotient}, truncating division, 64-bit to avoid overflow traps.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider stand-in: ready after 34 consecutive valid edges, counter cleared when valid drops.
  always @(posedge clk) begin
    if (!div_valid) div_cnt <= 0;
    else            div_cnt <= div_cnt + 1;
  end
  assign div_ready = div_valid && (div_cnt == 34);
  always_comb div_result = ref_div(div_signed, div_op1, div_op2);

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One divide request from IDLE (cycle 0) through DONE and one idle cycle after.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int flush_cyc, input string tag);
    int done_cyc;
    done_cyc = (b == 32'd0) ? 1 : 36;
    req = 1'b1; sgn_in = s; op1_in = a; op2_in = b; flush = 1'b0;
    #1;
    check({tag, " stall c0"}, 64'(stall), 64'd1);
    check({tag, " valid c0"}, 64'(div_valid), 64'd0);
    for (int c = 1; c <= done_cyc; c++) begin
      step();
      if (c == flush_cyc) begin
        flush = 1'b1; req = 1'b0;
        #1;
        check({tag, " stall flush"}, 64'(stall), 64'd0);
        check({tag, " rvalid flush"}, 64'(result_valid), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check({tag, " valid after flush"}, 64'(div_valid), 64'd0);
        check({tag, " stall after flush"}, 64'(stall), 64'd0);
        check({tag, " rvalid after flush"}, 64'(result_valid), 64'd0);
        check({tag, " result held flush"}, result, last_res);
        return;
      end
      if (c < done_cyc) begin
        sgn_in = 1'($urandom); op1_in = $urandom; op2_in = $urandom | 32'd1;
        #1;
        check({tag, " stall busy"}, 64'(stall), 64'd1);
        check({tag, " valid busy"}, 64'(div_valid), 64'd1);
        check({tag, " op1 busy"}, 64'(div_op1), 64'(a));
        check({tag, " op2 busy"}, 64'(div_op2), 64'(b));
        check({tag, " sgn busy"}, 64'(div_signed), 64'(s));
        check({tag, " rvalid busy"}, 64'(result_valid), 64'd0);
      end else begin
        req = 1'b0;
        #1;
        check({tag, " stall done"}, 64'(stall), 64'd0);
        check({tag, " rvalid done"}, 64'(result_valid), 64'd1);
        check({tag, " valid done"}, 64'(div_valid), 64'd0);
        check({tag, " result"}, result, exp_res);
        last_res = exp_res;
      end
    end
    step();
    #1;
    check({tag, " rvalid idle"}, 64'(result_valid), 64'd0);
    check({tag, " valid idle"}, 64'(div_valid), 64'd0);
    check({tag, " result hold"}, result, last_res);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    int          fc;
    rst = 1'b0; req = 1'b0; sgn_in = 1'b0; op1_in = '0; op2_in = '0; flush = 1'b0;
    last_res = '0;
    #2;
    check("reset stall", 64'(stall), 64'd0);
    check("reset valid", 64'(div_valid), 64'd0);
    check("reset rvalid", 64'(result_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset op1", 64'(div_op1), 64'd0);
    step();
    rst = 1'b1;
    step();

    do_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, -1, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1, "div_m7_2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, -1, "div_ovf");
    do_div(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, -1, "divu_by0");
    do_div(1'b0, 32'd100, 32'd7, 64'd0, 10, "flush_c10");
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, -1, "divu_9_3");

    req = 1'b1; sgn_in = 1'b0; op1_in = 32'd1000; op2_in = 32'd3;
    for (int c = 1; c <= 20; c++) step();
    rst = 1'b0; req = 1'b0;
    #1;
    check("rst stall", 64'(stall), 64'd0);
    check("rst valid", 64'(div_valid), 64'd0);
    check("rst sgn", 64'(div_signed), 64'd0);
    check("rst op1", 64'(div_op1), 64'd0);
    check("rst op2", 64'(div_op2), 64'd0);
    check("rst rvalid", 64'(result_valid), 64'd0);
    check("rst result", result, 64'd0);
    last_res = '0;
    step();
    rst = 1'b1;
    step();
    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, -1, "divu_50_5");

    do_div(1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, -1, "b2b_first");
    do_div(1'b0, 32'd11, 32'd4, {32'd3, 32'd2}, -1, "b2b_second");

    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom >> $urandom_range(0, 28)) | 32'd1);
      fc = (b != 32'd0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 35)) : -1;
      do_div(s, a, b, ref_div(s, a, b), fc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
